// File: rtl/div_pkg.sv
// Shared constants for the multi-cycle divider next to the EX stage.
// State encodings, handshake levels and the stall-request helper used by EX.
package div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam int unsigned RegBusW       = 32;
    localparam int unsigned DoubleRegBusW = 64;
    localparam logic [RegBusW-1:0] ZeroWord = '0;

    // EX holds the pipeline while a divide is requested and its result is not yet back.
    function automatic logic div_stall_req(input logic start, input logic ready);
        return (start == DivStart && ready == DivResultNotReady) ? Stop : NoStop;
    endfunction

endpackage

// File: rtl/div_if.sv
// Request/result bundle between the EX stage (master) and the divider (slave).
interface div_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift the working register left, trial-subtract the
// divisor from the upper half and keep the difference when it does not go negative.
module div_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] work_i,
    input  logic [DATA_W-1:0]   divisor_i,
    output logic [2*DATA_W-1:0] work_o
);
    // Upper half after the shift, keeping the bit shifted out so large divisors still work.
    logic [DATA_W:0]   upper;
    logic [DATA_W+1:0] trial;

    assign upper = work_i[2*DATA_W-1:DATA_W-1];
    assign trial = {1'b0, upper} - {2'b00, divisor_i};

    always_comb begin
        work_o = {work_i[2*DATA_W-2:0], 1'b0};
        if (!trial[DATA_W+1]) begin
            work_o = {trial[DATA_W-1:0], work_i[DATA_W-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/div.sv
// Multi-cycle restoring divider (DIV/DIVU); result is {remainder, quotient} for HI/LO.
// Operands are captured as magnitudes on start; sign fix-up is applied on the last step.
module div
    import div_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input logic  clk,
    input logic  rst,
    div_if.slave bus
);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] work_q, work_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic                neg_a_q, neg_a_d;
    logic                neg_b_q, neg_b_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic                neg_a, neg_b;
    logic [DATA_W-1:0]   abs_a, abs_b;
    logic [2*DATA_W-1:0] step_work;
    logic [DATA_W-1:0]   quot_step, rem_step, quot_fix, rem_fix;

    assign neg_a = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    assign neg_b = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    assign abs_a = neg_a ? -bus.opdata1_i : bus.opdata1_i;
    assign abs_b = neg_b ? -bus.opdata2_i : bus.opdata2_i;

    div_step #(
        .DATA_W(DATA_W)
    ) u_step (
        .work_i   (work_q),
        .divisor_i(divisor_q),
        .work_o   (step_work)
    );

    // neg_*_q already include the signed flag, so unsigned divides are never corrected.
    assign quot_step = step_work[DATA_W-1:0];
    assign rem_step  = step_work[2*DATA_W-1:DATA_W];
    assign quot_fix  = (neg_a_q ^ neg_b_q) ? -quot_step : quot_step;
    assign rem_fix   = neg_a_q ? -rem_step : rem_step;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            DivFree: begin
                ready_d  = DivResultNotReady;
                result_d = '0;
                if (bus.start_i == DivStart && !bus.annul_i) begin
                    neg_a_d   = neg_a;
                    neg_b_d   = neg_b;
                    work_d    = {{DATA_W{1'b0}}, abs_a};
                    divisor_d = abs_b;
                    cnt_d     = '0;
                    state_d   = (bus.opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                if (bus.annul_i) begin
                    state_d = DivFree;
                    cnt_d   = '0;
                end else begin
                    work_d  = '0;
                    state_d = DivEnd;
                end
            end
            DivOn: begin
                if (bus.annul_i) begin
                    state_d = DivFree;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    work_d  = {rem_fix, quot_fix};
                    cnt_d   = '0;
                    state_d = DivEnd;
                end else begin
                    work_d = step_work;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            DivEnd: begin
                if (bus.start_i == DivStart) begin
                    ready_d  = DivResultReady;
                    result_d = work_q;
                end else begin
                    ready_d  = DivResultNotReady;
                    result_d = '0;
                    state_d  = DivFree;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule
